hdb3_tx_sched: RTL

HDB3_TX_SCHED -- requirements
Module: hdb3_tx_sched

---
 rtl/hdb3_tx_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/hdb3_tx_sched.sv
// Two-requester byte scheduler feeding a serial bit stream to an HDB3 encoder.
// Bytes are accepted from a round-robin arbiter on bit-period ticks and shifted
// out MSB first, back-to-back when another byte is waiting.
module hdb3_tx_sched #(
    parameter int unsigned DIV      = 25,
    parameter bit          IDLE_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       data_out,
    output logic       bit_stb,
    output logic       busy,
    output logic       grant
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [7:0] CntMax = 8'(DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       bit_stb_q;

    logic       tick;
    logic       any_valid;
    logic       sel;
    logic       can_accept;
    logic       accept;
    logic [7:0] load_data;

    assign tick       = enable && (cnt_q == CntMax);
    assign any_valid  = req0_valid || req1_valid;
    // With both valid the requester that did not win last time takes the slot.
    assign sel        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign can_accept = (state_q == StIdle) || (idx_q == 3'd0);
    assign accept     = tick && any_valid && can_accept;
    assign load_data  = sel ? req1_data : req0_data;

    // Ready pulses are combinational so the requester sees them in the tick cycle.
    assign req0_ready = rst_n && accept && !sel;
    assign req1_ready = rst_n && accept && sel;

    assign data_out = (state_q == StShift) ? shreg_q[7] : IDLE_BIT;
    assign busy     = (state_q == StShift);
    assign bit_stb  = bit_stb_q;
    assign grant    = grant_q;

    // Bit-period counter: wraps at DIV-1, frozen while enable is low.
    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == CntMax) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    // Next-state logic for the accept/shift FSM and the arbiter history.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (tick) begin
            if (accept) begin
                shreg_d = load_data;
                idx_d   = 3'd7;
                state_d = StShift;
                grant_d = sel;
                last_d  = sel;
            end else begin
                case (state_q)
                    StShift: begin
                        if (idx_q != 3'd0) begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                            idx_d   = idx_q - 3'd1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            shreg_q   <= 8'd0;
            idx_q     <= 3'd0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            bit_stb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            bit_stb_q <= tick;
        end
    end

endmodule
